mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have inputs: es_to_ms_valid 1 (EX holds a valid instruction); es_rf_collect 39 = {res_from_mem, rf_we, rf_waddr[4:0], ex_result[31:0]}.
REQ-004 SHALL have inputs: es_mem_inst_bus 5 = {ld_b, ld_bu, ld_h, ld_hu, ld_w}; es_pc 32; es_to_ms_bus 7 = {ale, adef, ine, syscall, brk, int, ertn}.
REQ-005 SHALL have inputs: data_req_accepted 1 (EX data request handshake completed this cycle); data_sram_data_ok 1; data_sram_rdata 32; ws_allowin 1; except_flush 1.
REQ-006 SHALL have outputs: ms_allowin 1; ms_to_ws_valid 1; ms_to_ws_bus 77 = {rf_we, rf_waddr[4:0], final_result[31:0], ms_pc[31:0], ms_except[6:0]}.
REQ-007 SHALL have outputs: ms_rf_collect 39 = {res_from_mem&ms_valid, rf_we&ms_valid, rf_waddr, final_result}; ms_data_pending 1; ms_except 7; ms_pc 32.

Function
REQ-008 SHALL register ms_valid: cleared on reset or except_flush; otherwise loaded with es_to_ms_valid when ms_allowin=1.
REQ-009 SHALL capture es_rf_collect, es_mem_inst_bus, es_pc, es_to_ms_bus only when es_to_ms_valid & ms_allowin; otherwise hold.
REQ-010 SHALL define ms_has_except = |ms_except[6:1]; ertn alone is not an exception.
REQ-011 SHALL define need_data = ms_valid & res_from_mem & ~ms_has_except; need_data=0 -> ms_ready_go=1 in the same cycle.
REQ-012 SHALL set ms_ready_go = ~need_data | buf_valid | (data_sram_data_ok & discard_cnt==0).
REQ-013 SHALL drive ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
REQ-014 SHALL hold a response buffer (rdata_buf 32, buf_valid 1): set on an accepted data_ok while need_data & ~buf_valid & ~(ms_to_ws_valid & ws_allowin); cleared when the instruction leaves MEM or on flush.
REQ-015 SHALL select load data = buf_valid ? rdata_buf : data_sram_rdata.
REQ-016 SHALL align using a = ex_result[1:0]: ld_b/ld_bu byte at bits [8a+7:8a], sign/zero-extended; ld_h/ld_hu half at a[1] (bits [15:0] or [31:16]), sign/zero-extended; ld_w full word.
REQ-017 SHALL set final_result = aligned load data when res_from_mem, else ex_result.
REQ-018 SHALL set ms_except = latched exception bits & {7{ms_valid}}; rf_we in ms_to_ws_bus = rf_we & ms_valid & ~ms_has_except.
REQ-019 SHALL assert ms_data_pending = need_data & ~ms_ready_go (ID must stall dependent consumers).
REQ-020 SHALL keep a 2-bit outstanding counter: +1 on data_req_accepted, -1 on data_sram_data_ok, unchanged when both; never exceed 2.
REQ-021 SHALL on except_flush load discard_cnt <= outstanding + data_req_accepted - data_sram_data_ok (same-cycle events counted); clear buf_valid.
REQ-022 SHALL drop any data_ok arriving with discard_cnt>0 (no buffer write, no ready_go) and decrement discard_cnt.
REQ-023 SHALL, with flush and an accepted data_ok in the same cycle, treat that data_ok as discarded-in-place (not counted in discard_cnt, not buffered).

Reset
REQ-024 SHALL on resetn=0 clear ms_valid, buf_valid, outstanding, discard_cnt, all latched bus fields; outputs then: ms_allowin=1, ms_to_ws_valid=0, ms_data_pending=0, ms_except=0, ms_pc=0, ms_rf_collect=0.
REQ-025 SHALL give reset priority over except_flush and all handshakes.

Verification
REQ-026 ld_b, ex_result=0x1003, rdata=0x80FF_FF00, data_ok 1 cycle after entry, ws_allowin=1 -> final_result=0xFFFF_FF80, ms_to_ws_valid for exactly 1 cycle.
REQ-027 ld_hu, ex_result=0x2002, data_ok while ws_allowin=0 for 3 cycles, rdata changes afterwards -> buf_valid=1, final_result=0x0000_xxxx from buffered upper half, held stable until ws_allowin=1.
REQ-028 add (res_from_mem=0, rf_we=1, waddr=5, ex_result=0x1234) -> ms_to_ws_valid next cycle, ms_rf_collect={0,1,5,0x1234}, ms_data_pending=0.
REQ-029 ld_w waiting (outstanding=1), except_flush pulse -> ms_valid=0, discard_cnt=1; next data_ok dropped; following new ld_w receives its own data_ok correctly.
REQ-030 ld_w with ale=1 -> no wait, ms_to_ws_valid immediately, rf_we=0, ms_except[6]=1; resetn=0 mid-wait -> all outputs at REQ-024 values next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the in-order pipeline.
//
// Takes an instruction from EX, waits for its load response from the data
// SRAM when one is needed, aligns and extends the loaded data, and hands the
// result to WB. A one-entry response buffer holds load data that arrives
// while WB is stalled. After an exception flush, responses still owed to
// killed requests are counted and silently dropped.
//
// Ports
//   clk, resetn         clock; synchronous active-low reset
//   es_to_ms_valid      EX holds a valid instruction
//   es_rf_collect[38:0] {res_from_mem, rf_we, rf_waddr[4:0], ex_result[31:0]}
//   es_mem_inst_bus[4:0]{ld_b, ld_bu, ld_h, ld_hu, ld_w}
//   es_pc[31:0]         PC of the EX instruction
//   es_to_ms_bus[6:0]   {ale, adef, ine, syscall, brk, int, ertn}
//   data_req_accepted   EX data request handshake completed this cycle
//   data_sram_data_ok   data SRAM response strobe
//   data_sram_rdata     data SRAM response word
//   ws_allowin          WB can accept an instruction
//   except_flush        kill the instruction in MEM
//   ms_allowin          MEM can accept an instruction
//   ms_to_ws_valid      MEM presents a finished instruction to WB
//   ms_to_ws_bus[76:0]  {rf_we, rf_waddr, final_result, ms_pc, ms_except}
//   ms_rf_collect[38:0] forwarding info for ID
//   ms_data_pending     MEM is still waiting for load data
//   ms_except[6:0]      exception bits of the valid MEM instruction
//   ms_pc[31:0]         PC of the MEM instruction
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        es_to_ms_valid,
   input  logic [38:0] es_rf_collect,
   input  logic [4:0]  es_mem_inst_bus,
   input  logic [31:0] es_pc,
   input  logic [6:0]  es_to_ms_bus,
   input  logic        data_req_accepted,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   input  logic        ws_allowin,
   input  logic        except_flush,
   output logic        ms_allowin,
   output logic        ms_to_ws_valid,
   output logic [76:0] ms_to_ws_bus,
   output logic [38:0] ms_rf_collect,
   output logic        ms_data_pending,
   output logic [6:0]  ms_except,
   output logic [31:0] ms_pc
);

   logic        ms_valid_q, ms_valid_d;
   logic [38:0] rf_collect_q, rf_collect_d;
   logic [4:0]  mem_inst_q, mem_inst_d;
   logic [31:0] pc_q, pc_d;
   logic [6:0]  except_q, except_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] rdata_buf_q, rdata_buf_d;
   logic [1:0]  outstanding_q, outstanding_d;
   logic [1:0]  discard_cnt_q, discard_cnt_d;

   logic        res_from_mem;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] ex_result;
   logic        ms_has_except;
   logic        need_data;
   logic        data_ok_live;
   logic        ms_ready_go;
   logic        ms_leave;
   logic [31:0] load_data;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] aligned_data;
   logic [31:0] final_result;
   logic [2:0]  flush_total;

   assign res_from_mem = rf_collect_q[38];
   assign rf_we        = rf_collect_q[37];
   assign rf_waddr     = rf_collect_q[36:32];
   assign ex_result    = rf_collect_q[31:0];

   // Handshake: ertn alone is not an exception, so it still waits for data.
   // A response only counts once every killed request has been drained.
   always_comb begin
      ms_has_except   = |except_q[6:1];
      need_data       = ms_valid_q & res_from_mem & ~ms_has_except;
      data_ok_live    = data_sram_data_ok & (discard_cnt_q == 2'd0);
      ms_ready_go     = ~need_data | buf_valid_q | data_ok_live;
      ms_allowin      = ~ms_valid_q | (ms_ready_go & ws_allowin);
      ms_to_ws_valid  = ms_valid_q & ms_ready_go;
      ms_leave        = ms_to_ws_valid & ws_allowin;
      ms_data_pending = need_data & ~ms_ready_go;
   end

   // Load alignment: byte lane picked by the low address bits, half by bit 1.
   always_comb begin
      load_data = buf_valid_q ? rdata_buf_q : data_sram_rdata;
      case (ex_result[1:0])
         2'd0:    load_byte = load_data[7:0];
         2'd1:    load_byte = load_data[15:8];
         2'd2:    load_byte = load_data[23:16];
         default: load_byte = load_data[31:24];
      endcase
      load_half = ex_result[1] ? load_data[31:16] : load_data[15:0];
      if (mem_inst_q[4]) begin
         aligned_data = {{24{load_byte[7]}}, load_byte};
      end else if (mem_inst_q[3]) begin
         aligned_data = {24'd0, load_byte};
      end else if (mem_inst_q[2]) begin
         aligned_data = {{16{load_half[15]}}, load_half};
      end else if (mem_inst_q[1]) begin
         aligned_data = {16'd0, load_half};
      end else begin
         aligned_data = load_data;
      end
      final_result = res_from_mem ? aligned_data : ex_result;
   end

   assign ms_except     = except_q & {7{ms_valid_q}};
   assign ms_pc         = pc_q;
   assign ms_to_ws_bus  = {rf_we & ms_valid_q & ~ms_has_except, rf_waddr,
                           final_result, pc_q, ms_except};
   assign ms_rf_collect = {res_from_mem & ms_valid_q, rf_we & ms_valid_q,
                           rf_waddr, final_result};

   // Pipeline register: the instruction fields are only refreshed on a real
   // transfer from EX, the valid bit is killed by a flush.
   always_comb begin
      ms_valid_d   = ms_valid_q;
      rf_collect_d = rf_collect_q;
      mem_inst_d   = mem_inst_q;
      pc_d         = pc_q;
      except_d     = except_q;
      if (except_flush) begin
         ms_valid_d = 1'b0;
      end else if (ms_allowin) begin
         ms_valid_d = es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
         rf_collect_d = es_rf_collect;
         mem_inst_d   = es_mem_inst_bus;
         pc_d         = es_pc;
         except_d     = es_to_ms_bus;
      end
   end

   // Response buffer: keeps load data that arrived while WB was stalled.
   always_comb begin
      buf_valid_d = buf_valid_q;
      rdata_buf_d = rdata_buf_q;
      if (except_flush || ms_leave) begin
         buf_valid_d = 1'b0;
      end else if (need_data && !buf_valid_q && data_ok_live) begin
         buf_valid_d = 1'b1;
         rdata_buf_d = data_sram_rdata;
      end
   end

   // Outstanding/discard bookkeeping. On a flush every response still owed
   // (including a request accepted this cycle) must be dropped later, except
   // a response arriving in the flush cycle itself, which dies in place.
   always_comb begin
      outstanding_d = outstanding_q;
      if (data_req_accepted && !data_sram_data_ok && outstanding_q != 2'd2) begin
         outstanding_d = outstanding_q + 2'd1;
      end else if (!data_req_accepted && data_sram_data_ok && outstanding_q != 2'd0) begin
         outstanding_d = outstanding_q - 2'd1;
      end

      flush_total = {1'b0, outstanding_q} + {2'b00, data_req_accepted};
      if (data_sram_data_ok && flush_total != 3'd0) begin
         flush_total = flush_total - 3'd1;
      end

      discard_cnt_d = discard_cnt_q;
      if (except_flush) begin
         discard_cnt_d = flush_total[1:0];
      end else if (data_sram_data_ok && discard_cnt_q != 2'd0) begin
         discard_cnt_d = discard_cnt_q - 2'd1;
      end
   end

   // State register; reset wins over flush and every handshake.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid_q    <= 1'b0;
         rf_collect_q  <= 39'd0;
         mem_inst_q    <= 5'd0;
         pc_q          <= 32'd0;
         except_q      <= 7'd0;
         buf_valid_q   <= 1'b0;
         rdata_buf_q   <= 32'd0;
         outstanding_q <= 2'd0;
         discard_cnt_q <= 2'd0;
      end else begin
         ms_valid_q    <= ms_valid_d;
         rf_collect_q  <= rf_collect_d;
         mem_inst_q    <= mem_inst_d;
         pc_q          <= pc_d;
         except_q      <= except_d;
         buf_valid_q   <= buf_valid_d;
         rdata_buf_q   <= rdata_buf_d;
         outstanding_q <= outstanding_d;
         discard_cnt_q <= discard_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- bench for mem_stage.
// A table of load alignment vectors, hand-written multi-cycle sequences for
// buffering, flush/discard, exceptions and reset, then a randomized phase in
// which the bench plays EX and the data SRAM and checks every cycle against
// a tag-based model of which response belongs to which instruction.
module tb_mem_stage;

   localparam logic [4:0] LD_B  = 5'b10000;
   localparam logic [4:0] LD_BU = 5'b01000;
   localparam logic [4:0] LD_H  = 5'b00100;
   localparam logic [4:0] LD_HU = 5'b00010;
   localparam logic [4:0] LD_W  = 5'b00001;

   logic        clk = 1'b0;
   logic        resetn;
   logic        es_to_ms_valid;
   logic [38:0] es_rf_collect;
   logic [4:0]  es_mem_inst_bus;
   logic [31:0] es_pc;
   logic [6:0]  es_to_ms_bus;
   logic        data_req_accepted;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ws_allowin;
   logic        except_flush;
   logic        ms_allowin;
   logic        ms_to_ws_valid;
   logic [76:0] ms_to_ws_bus;
   logic [38:0] ms_rf_collect;
   logic        ms_data_pending;
   logic [6:0]  ms_except;
   logic [31:0] ms_pc;

   int vectors = 0;
   int miscompares = 0;

   mem_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_rf_collect     (es_rf_collect),
      .es_mem_inst_bus   (es_mem_inst_bus),
      .es_pc             (es_pc),
      .es_to_ms_bus      (es_to_ms_bus),
      .data_req_accepted (data_req_accepted),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ws_allowin        (ws_allowin),
      .except_flush      (except_flush),
      .ms_allowin        (ms_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ms_rf_collect     (ms_rf_collect),
      .ms_data_pending   (ms_data_pending),
      .ms_except         (ms_except),
      .ms_pc             (ms_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  inst;
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [31:0] expected;
   } align_vec_t;

   typedef struct {
      logic [31:0] data;
      int          tag;
   } resp_t;

   // Drives every DUT input for the current cycle.
   task automatic applyStimulus(input logic es_valid, input logic [38:0] rfc,
                                input logic [4:0] inst, input logic [31:0] pc,
                                input logic [6:0] exc, input logic req,
                                input logic dok, input logic [31:0] rdata,
                                input logic ws, input logic flush);
      es_to_ms_valid    = es_valid;
      es_rf_collect     = rfc;
      es_mem_inst_bus   = inst;
      es_pc             = pc;
      es_to_ms_bus      = exc;
      data_req_accepted = req;
      data_sram_data_ok = dok;
      data_sram_rdata   = rdata;
      ws_allowin        = ws;
      except_flush      = flush;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic checkOutput(input string name, input logic [76:0] act,
                              input logic [76:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load extension computed from the lane rules with plain arithmetic.
   function automatic logic [31:0] load_align(input logic [4:0] inst,
                                              input logic [1:0] a,
                                              input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (a >= 2'd2) ? (w >> 16) : (w & 32'hFFFF);
      if (inst == LD_B)  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      if (inst == LD_BU) return b;
      if (inst == LD_H)  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      if (inst == LD_HU) return h;
      return w;
   endfunction

   task automatic checkReset(input string tag);
      checkOutput({tag, ".allowin"}, 77'(ms_allowin), 77'd1);
      checkOutput({tag, ".to_ws_valid"}, 77'(ms_to_ws_valid), 77'd0);
      checkOutput({tag, ".pending"}, 77'(ms_data_pending), 77'd0);
      checkOutput({tag, ".except"}, 77'(ms_except), 77'd0);
      checkOutput({tag, ".pc"}, 77'(ms_pc), 77'd0);
      checkOutput({tag, ".rf_collect"}, 77'(ms_rf_collect), 77'd0);
   endtask

   align_vec_t avec[11];

   // Model state for the randomized phase.
   logic        slot_valid;
   logic [38:0] slot_rfc;
   logic [4:0]  slot_inst;
   logic [31:0] slot_pc;
   logic [6:0]  slot_exc;
   int          slot_id;
   logic        slot_has;
   logic [31:0] slot_data;
   resp_t       memq[$];
   logic        ex_valid;
   logic [38:0] ex_rfc;
   logic [4:0]  ex_inst;
   logic [31:0] ex_pc;
   logic [6:0]  ex_exc;
   int          ex_id;
   logic        ex_needreq;
   int          next_id;

   initial begin
      avec[0]  = '{LD_B,  32'h1003, 32'h80FF_FF00, 32'hFFFF_FF80};
      avec[1]  = '{LD_BU, 32'h1003, 32'h80FF_FF00, 32'h0000_0080};
      avec[2]  = '{LD_B,  32'h1000, 32'h1234_567F, 32'h0000_007F};
      avec[3]  = '{LD_B,  32'h1001, 32'h1234_8000, 32'hFFFF_FF80};
      avec[4]  = '{LD_BU, 32'h1002, 32'h12AB_0000, 32'h0000_00AB};
      avec[5]  = '{LD_H,  32'h2000, 32'h0000_8001, 32'hFFFF_8001};
      avec[6]  = '{LD_H,  32'h2002, 32'h7FFF_0000, 32'h0000_7FFF};
      avec[7]  = '{LD_HU, 32'h2002, 32'hBEEF_1234, 32'h0000_BEEF};
      avec[8]  = '{LD_HU, 32'h2000, 32'hBEEF_9234, 32'h0000_9234};
      avec[9]  = '{LD_W,  32'h3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      avec[10] = '{LD_H,  32'h2003, 32'hC000_0000, 32'hFFFF_C000};

      // Reset state
      idle();
      resetn = 1'b0;
      step();
      step();
      #2;
      checkReset("reset");
      resetn = 1'b1;
      step();

      // Alignment table: data_ok one cycle after entry, WB always ready
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b1, {1'b1, 1'b1, 5'd3, avec[i].addr}, avec[i].inst,
                       32'h1C00_0000 + 32'(i * 4), 7'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
         #2;
         checkOutput($sformatf("vec%0d.allowin", i), 77'(ms_allowin), 77'd1);
         step();
         applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b1, avec[i].rdata, 1'b1, 1'b0);
         #2;
         checkOutput($sformatf("vec%0d.to_ws_valid", i), 77'(ms_to_ws_valid), 77'd1);
         checkOutput($sformatf("vec%0d.final", i), 77'(ms_to_ws_bus[70:39]), 77'(avec[i].expected));
         step();
         idle();
         #2;
         checkOutput($sformatf("vec%0d.one_cycle", i), 77'(ms_to_ws_valid), 77'd0);
      end

      // ALU result passes straight through
      applyStimulus(1'b1, {1'b0, 1'b1, 5'd5, 32'h1234}, 5'd0, 32'h1C00_0100, 7'd0,
                    1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      step();
      idle();
      #2;
      checkOutput("add.to_ws_valid", 77'(ms_to_ws_valid), 77'd1);
      checkOutput("add.rf_collect", 77'(ms_rf_collect), 77'({1'b0, 1'b1, 5'd5, 32'h1234}));
      checkOutput("add.pending", 77'(ms_data_pending), 77'd0);
      checkOutput("add.pc", 77'(ms_pc), 77'h1C00_0100);
      step();

      // ld_hu response buffered while WB stalls for three cycles
      applyStimulus(1'b1, {1'b1, 1'b1, 5'd6, 32'h2002}, LD_HU, 32'h1C00_0200, 7'd0,
                    1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b1, 32'hCAFE_1111, 1'b0, 1'b0);
      #2;
      checkOutput("ldhu.first_valid", 77'(ms_to_ws_valid), 77'd1);
      checkOutput("ldhu.first_final", 77'(ms_to_ws_bus[70:39]), 77'h0000_CAFE);
      checkOutput("ldhu.stalled_allowin", 77'(ms_allowin), 77'd0);
      for (int c = 0; c < 2; c++) begin
         step();
         applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b0, 32'h5555_AAAA + 32'(c), 1'b0, 1'b0);
         #2;
         checkOutput($sformatf("ldhu.held%0d_valid", c), 77'(ms_to_ws_valid), 77'd1);
         checkOutput($sformatf("ldhu.held%0d_final", c), 77'(ms_to_ws_bus[70:39]), 77'h0000_CAFE);
         checkOutput($sformatf("ldhu.held%0d_pending", c), 77'(ms_data_pending), 77'd0);
      end
      step();
      applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b0, 32'h0123_4567, 1'b1, 1'b0);
      #2;
      checkOutput("ldhu.release_final", 77'(ms_to_ws_bus[70:39]), 77'h0000_CAFE);
      checkOutput("ldhu.release_allowin", 77'(ms_allowin), 77'd1);
      step();
      idle();
      #2;
      checkOutput("ldhu.gone", 77'(ms_to_ws_valid), 77'd0);

      // ertn alone still waits for data and keeps rf_we
      applyStimulus(1'b1, {1'b1, 1'b1, 5'd9, 32'h4000}, LD_W, 32'h1C00_0300, 7'h01,
                    1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      idle();
      #2;
      checkOutput("ertn.pending", 77'(ms_data_pending), 77'd1);
      checkOutput("ertn.except", 77'(ms_except), 77'h01);
      step();
      applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
      #2;
      checkOutput("ertn.bus", ms_to_ws_bus, {1'b1, 5'd9, 32'h0BAD_F00D, 32'h1C00_0300, 7'h01});
      step();
      idle();

      // Flush while a ld_w waits; its stale response must be dropped
      applyStimulus(1'b1, {1'b1, 1'b1, 5'd4, 32'h5000}, LD_W, 32'h1C00_0400, 7'd0,
                    1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      idle();
      #2;
      checkOutput("flush.wait_pending", 77'(ms_data_pending), 77'd1);
      checkOutput("flush.wait_allowin", 77'(ms_allowin), 77'd0);
      step();
      applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      step();
      applyStimulus(1'b1, {1'b1, 1'b1, 5'd8, 32'h6000}, LD_W, 32'h1C00_0500, 7'd0,
                    1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      #2;
      checkOutput("flush.killed_valid", 77'(ms_to_ws_valid), 77'd0);
      checkOutput("flush.killed_allowin", 77'(ms_allowin), 77'd1);
      step();
      applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0);
      #2;
      checkOutput("flush.stale_dropped", 77'(ms_to_ws_valid), 77'd0);
      checkOutput("flush.stale_pending", 77'(ms_data_pending), 77'd1);
      step();
      applyStimulus(1'b0, 39'd0, 5'd0, 32'd0, 7'd0, 1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0);
      #2;
      checkOutput("flush.own_valid", 77'(ms_to_ws_valid), 77'd1);
      checkOutput("flush.own_bus", ms_to_ws_bus, {1'b1, 5'd8, 32'h2222_2222, 32'h1C00_0500, 7'd0});
      step();
      idle();
      #2;
      checkOutput("flush.own_gone", 77'(ms_to_ws_valid), 77'd0);

      // ld_w with ale: no wait, write suppressed
      applyStimulus(1'b1, {1'b1, 1'b1, 5'd7, 32'h3001}, LD_W, 32'h1C00_0600, 7'h40,
                    1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      idle();
      #2;
      checkOutput("ale.to_ws_valid", 77'(ms_to_ws_valid), 77'd1);
      checkOutput("ale.pending", 77'(ms_data_pending), 77'd0);
      checkOutput("ale.rf_we", 77'(ms_to_ws_bus[76]), 77'd0);
      checkOutput("ale.except", 77'(ms_except), 77'h40);
      step();

      // Reset while a load waits
      applyStimulus(1'b1, {1'b1, 1'b1, 5'd2, 32'h7000}, LD_W, 32'h1C00_0700, 7'd0,
                    1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      idle();
      #2;
      checkOutput("midreset.pending_before", 77'(ms_data_pending), 77'd1);
      resetn = 1'b0;
      applyStimulus(1'b1, {1'b1, 1'b1, 5'd2, 32'h7000}, LD_W, 32'h1C00_0800, 7'h40,
                    1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      step();
      idle();
      #2;
      checkReset("midreset");
      resetn = 1'b1;
      step();

      // Randomized phase against the tag-based model
      slot_valid = 1'b0;
      slot_rfc   = 39'd0;
      slot_inst  = 5'd0;
      slot_pc    = 32'd0;
      slot_exc   = 7'd0;
      slot_id    = -2;
      slot_has   = 1'b0;
      slot_data  = 32'd0;
      ex_valid   = 1'b0;
      ex_rfc     = 39'd0;
      ex_inst    = 5'd0;
      ex_pc      = 32'd0;
      ex_exc     = 7'd0;
      ex_id      = 0;
      ex_needreq = 1'b0;
      next_id    = 0;
      memq.delete();

      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        ws, fl, dok, req, need, deliver, ready, leave, has_exc, taken;
         logic [31:0] rd, data, fin;
         logic [76:0] exp_bus;
         logic [38:0] exp_col;
         resp_t       head;

         ws  = ($urandom_range(0, 9) < 7);
         fl  = ($urandom_range(0, 19) == 0);
         dok = (memq.size() > 0) && ($urandom_range(0, 1) == 1);
         rd  = dok ? memq[0].data : $urandom;

         if (!ex_valid && $urandom_range(0, 9) < 6) begin
            logic is_load;
            is_load    = ($urandom_range(0, 1) == 1) && (memq.size() < 2);
            ex_valid   = 1'b1;
            ex_exc     = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0;
            ex_rfc     = {is_load, 1'($urandom), 5'($urandom), $urandom};
            ex_inst    = is_load ? (5'd1 << $urandom_range(0, 4)) : 5'd0;
            ex_pc      = $urandom;
            ex_id      = next_id;
            next_id++;
            ex_needreq = is_load && (ex_exc[6:1] == 6'd0);
         end

         has_exc = (slot_exc[6:1] != 6'd0);
         need    = slot_valid && slot_rfc[38] && !has_exc;
         deliver = dok && need && (memq[0].tag == slot_id);
         ready   = !need || slot_has || deliver;
         data    = slot_has ? slot_data : rd;
         fin     = slot_rfc[38] ? load_align(slot_inst, slot_rfc[1:0], data) : slot_rfc[31:0];
         exp_bus = {slot_rfc[37] && slot_valid && !has_exc, slot_rfc[36:32], fin, slot_pc,
                    slot_valid ? slot_exc : 7'd0};
         exp_col = {slot_rfc[38] && slot_valid, slot_rfc[37] && slot_valid, slot_rfc[36:32], fin};
         taken   = ex_valid && (!slot_valid || (ready && ws));
         req     = taken && ex_needreq;

         if (ex_valid) begin
            applyStimulus(1'b1, ex_rfc, ex_inst, ex_pc, ex_exc, req, dok, rd, ws, fl);
         end else begin
            applyStimulus(1'b0, {$urandom, $urandom}, 5'($urandom), $urandom, 7'($urandom),
                          1'b0, dok, rd, ws, fl);
         end
         #2;
         checkOutput($sformatf("rand%0d.allowin", cyc), 77'(ms_allowin),
                     77'(!slot_valid || (ready && ws)));
         checkOutput($sformatf("rand%0d.to_ws_valid", cyc), 77'(ms_to_ws_valid),
                     77'(slot_valid && ready));
         checkOutput($sformatf("rand%0d.pending", cyc), 77'(ms_data_pending), 77'(need && !ready));
         checkOutput($sformatf("rand%0d.bus", cyc), ms_to_ws_bus, exp_bus);
         checkOutput($sformatf("rand%0d.rf_collect", cyc), 77'(ms_rf_collect), 77'(exp_col));

         leave = slot_valid && ready && ws;
         if (dok) begin
            head = memq.pop_front();
            if (need && head.tag == slot_id && !leave && !fl) begin
               slot_has  = 1'b1;
               slot_data = head.data;
            end
         end
         if (req) memq.push_back('{data: $urandom, tag: ex_id});
         if (fl) begin
            foreach (memq[i]) memq[i].tag = -1;
         end
         if (taken) begin
            slot_rfc  = ex_rfc;
            slot_inst = ex_inst;
            slot_pc   = ex_pc;
            slot_exc  = ex_exc;
            slot_id   = ex_id;
            ex_valid  = 1'b0;
         end
         if (fl) begin
            slot_valid = 1'b0;
            slot_has   = 1'b0;
         end else if (!slot_valid || (ready && ws)) begin
            slot_valid = taken;
            slot_has   = 1'b0;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
